// File: rtl/wb_stage_if.sv
// MEM-to-WB handoff: transfer strobe, result/exception bundles and the WB accept signal.
// Shared by the memory stage (master) and the write-back stage (slave).
interface wb_stage_if #(
    parameter int EX_W = 87,
    parameter int WB_W = 103
);
    logic              MEM_to_WB;
    logic [WB_W-1:0]   MEM_to_WB_zip;
    logic [EX_W+31:0]  MEM_except_zip;
    logic              WB_allowin;

    modport master (
        output MEM_to_WB,
        output MEM_to_WB_zip,
        output MEM_except_zip,
        input  WB_allowin
    );

    modport slave (
        input  MEM_to_WB,
        input  MEM_to_WB_zip,
        input  MEM_except_zip,
        output WB_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM results and commits RF/CSR writes, exceptions and ERTN in one cycle.
// Define WB_DEBUG_TRACE_EN to expose the debug_wb_* commit trace ports.
module wb_stage #(
    parameter int EX_W = 87,
    parameter int WB_W = 103
) (
    input  logic        clk,
    input  logic        resetn,
    wb_stage_if.slave   mem_wb,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        ex_commit,
    output logic [5:0]  ex_ecode,
    output logic [31:0] ex_era,
    output logic        ex_badv_we,
    output logic [31:0] ex_badv,
    output logic        ertn_commit,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era_value,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        back_valid,
    output logic [4:0]  back_addr,
    output logic [31:0] back_data,
`ifdef WB_DEBUG_TRACE_EN
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
`endif
    output logic        WB_is_csr
);

    logic [WB_W-1:0]  result_q, result_d;
    logic [EX_W+31:0] except_q, except_d;
    logic             busy_q, busy_d;

    always_comb begin
        result_d = result_q;
        except_d = except_q;
        busy_d   = mem_wb.MEM_to_WB;
        if (mem_wb.MEM_to_WB) begin
            result_d = mem_wb.MEM_to_WB_zip;
            except_d = mem_wb.MEM_except_zip;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
            except_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            except_q <= except_d;
            busy_q   <= busy_d;
        end
    end

    logic              zip_valid;
    logic [31:0]       pc;
    logic              gr_we;
    logic [4:0]        zip_waddr;
    logic [31:0]       zip_wdata;
    logic [EX_W-1:0]   ex_zip;
    logic [31:0]       badv_addr;
    logic              unused_ir;

    assign zip_valid = result_q[102];
    assign pc        = result_q[101:70];
    assign gr_we     = result_q[37];
    assign zip_waddr = result_q[36:32];
    assign zip_wdata = result_q[31:0];
    assign unused_ir = ^result_q[69:38];
    assign ex_zip    = except_q[EX_W+31:32];
    assign badv_addr = except_q[31:0];

    logic ale, adef, syscall, brk, ine, intr, ertn, csr_we_bit, csr_re;
    assign ale        = ex_zip[0];
    assign adef       = ex_zip[1];
    assign syscall    = ex_zip[2];
    assign brk        = ex_zip[3];
    assign ine        = ex_zip[4];
    assign intr       = ex_zip[5];
    assign ertn       = ex_zip[6];
    assign csr_we_bit = ex_zip[7];
    assign csr_re     = ex_zip[86];

    logic valid, exc, sel_adef, sel_ale;
    logic [5:0] ecode;

    assign valid = busy_q & zip_valid;
    assign exc   = valid & (intr | adef | ine | syscall | brk | ale);

    // Priority: int > adef > ine > syscall > break > ale
    always_comb begin
        ecode    = 6'h00;
        sel_adef = 1'b0;
        sel_ale  = 1'b0;
        if (intr) begin
            ecode = 6'h00;
        end else if (adef) begin
            ecode    = 6'h08;
            sel_adef = 1'b1;
        end else if (ine) begin
            ecode = 6'h0D;
        end else if (syscall) begin
            ecode = 6'h0B;
        end else if (brk) begin
            ecode = 6'h0C;
        end else if (ale) begin
            ecode   = 6'h09;
            sel_ale = 1'b1;
        end
    end

    assign mem_wb.WB_allowin = 1'b1;

    assign ex_commit   = exc;
    assign ex_ecode    = exc ? ecode : 6'h00;
    assign ex_era      = pc;
    assign ex_badv_we  = exc & (sel_adef | sel_ale);
    assign ex_badv     = sel_adef ? pc : badv_addr;
    assign ertn_commit = valid & ertn & ~exc;

    assign flush        = ex_commit | ertn_commit;
    assign flush_target = ex_commit ? ex_entry : era_value;

    assign rf_we    = valid & gr_we & ~exc;
    assign rf_waddr = zip_waddr;
    assign rf_wdata = csr_re ? csr_rvalue : zip_wdata;

    assign csr_we     = valid & csr_we_bit & ~exc;
    assign csr_num    = ex_zip[21:8];
    assign csr_wmask  = ex_zip[53:22];
    assign csr_wvalue = ex_zip[85:54];

    assign back_valid = rf_we;
    assign back_addr  = rf_waddr;
    assign back_data  = rf_wdata;
    assign WB_is_csr  = valid & (csr_re | csr_we_bit | ertn);

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
